// File: rtl/cnn_pkg.sv
// Shared types and constants for the conv_5 column collector, including the
// shift-and-saturate requantiser used on the drain path.
package cnn_pkg;

  localparam int unsigned IN_WIDTH   = 32;
  localparam int unsigned OUT_WIDTH  = 16;
  localparam int unsigned OUT_SIZE   = 24;
  localparam int unsigned FRAC_SHIFT = 8;
  localparam int unsigned CNT_W      = $clog2(OUT_SIZE);

  typedef logic signed [IN_WIDTH-1:0]  acc_t;
  typedef logic signed [OUT_WIDTH-1:0] q_t;

  typedef enum logic [1:0] {
    COLL_IDLE    = 2'd0,
    COLL_CAPTURE = 2'd1,
    COLL_DRAIN   = 2'd2
  } coll_state_t;

  // Saturation limits expressed at accumulator width so the compare stays signed
  localparam acc_t SAT_MAX = acc_t'((IN_WIDTH'(1) << (OUT_WIDTH - 1)) - IN_WIDTH'(1));
  localparam acc_t SAT_MIN = ~SAT_MAX;

  function automatic q_t requant(input acc_t x);
    acc_t y;
    y = x >>> FRAC_SHIFT;
    if (y > SAT_MAX) begin
      return SAT_MAX[OUT_WIDTH-1:0];
    end else if (y < SAT_MIN) begin
      return SAT_MIN[OUT_WIDTH-1:0];
    end
    return y[OUT_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/col_requant.sv
// Combinational requantiser: arithmetic shift, saturate, optional ReLU.
// Build option: CONV_COLL_RELU_EN clamps negative results to zero.
module col_requant
  import cnn_pkg::*;
(
  input  logic signed [IN_WIDTH-1:0]  x,
  output logic signed [OUT_WIDTH-1:0] y_c
);

  q_t sat;

  always_comb begin
    sat = requant(x);
`ifdef CONV_COLL_RELU_EN
    y_c = sat[OUT_WIDTH-1] ? '0 : sat;
`else
    y_c = sat;
`endif
  end

endmodule

// File: rtl/conv_col_collector.sv
// Collects OUT_SIZE result columns into a feature-map buffer, then drains it
// row-major and requantised over valid/ready. Build option: CONV_COLL_RELU_EN.
module conv_col_collector
  import cnn_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  input  logic signed [IN_WIDTH-1:0]  in_data [OUT_SIZE],
  output logic                        in_ready,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [OUT_WIDTH-1:0] out_data,
  output logic                        out_last,
  output logic                        frame_done,
  output logic                        overflow
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(OUT_SIZE - 1);

  coll_state_t      state_q, state_d;
  logic [CNT_W-1:0] col_cnt, col_cnt_d;
  logic [CNT_W-1:0] row_cnt, row_cnt_d;
  logic [CNT_W-1:0] drain_col, drain_col_d;
  logic             rd_done, rd_done_d;
  logic             in_ready_d, out_valid_d, out_last_d, frame_done_d, overflow_d;
  logic             wr_en, rd_en;
  acc_t             mem [OUT_SIZE][OUT_SIZE];
  q_t               rd_q_c;

  // Next-state and next-output logic
  always_comb begin
    state_d      = state_q;
    col_cnt_d    = col_cnt;
    row_cnt_d    = row_cnt;
    drain_col_d  = drain_col;
    rd_done_d    = rd_done;
    out_valid_d  = out_valid;
    out_last_d   = out_last;
    frame_done_d = 1'b0;
    overflow_d   = overflow;
    wr_en        = 1'b0;
    rd_en        = 1'b0;

    unique case (state_q)
      COLL_IDLE, COLL_CAPTURE: begin
        if (in_valid) begin
          wr_en   = 1'b1;
          state_d = COLL_CAPTURE;
          if (col_cnt == LAST_IDX) begin
            col_cnt_d   = '0;
            row_cnt_d   = '0;
            drain_col_d = '0;
            rd_done_d   = 1'b0;
            state_d     = COLL_DRAIN;
          end else begin
            col_cnt_d = col_cnt + 1'b1;
          end
        end
      end
      COLL_DRAIN: begin
        if (in_valid) begin
          overflow_d = 1'b1;
        end
        if (out_valid && out_ready) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          if (out_last) begin
            frame_done_d = 1'b1;
            row_cnt_d    = '0;
            state_d      = COLL_IDLE;
          end
        end
        // Fetch the next element when the output slot is empty or emptying
        if (!rd_done && (!out_valid || out_ready)) begin
          rd_en       = 1'b1;
          out_valid_d = 1'b1;
          out_last_d  = (row_cnt == LAST_IDX) && (drain_col == LAST_IDX);
          if (drain_col == LAST_IDX) begin
            drain_col_d = '0;
            if (row_cnt == LAST_IDX) begin
              rd_done_d = 1'b1;
            end else begin
              row_cnt_d = row_cnt + 1'b1;
            end
          end else begin
            drain_col_d = drain_col + 1'b1;
          end
        end
      end
      default: state_d = COLL_IDLE;
    endcase

    in_ready_d = (state_d != COLL_DRAIN);
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= COLL_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Control and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_cnt    <= '0;
      row_cnt    <= '0;
      drain_col  <= '0;
      rd_done    <= 1'b0;
      in_ready   <= 1'b0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      out_data   <= '0;
      frame_done <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      col_cnt    <= col_cnt_d;
      row_cnt    <= row_cnt_d;
      drain_col  <= drain_col_d;
      rd_done    <= rd_done_d;
      in_ready   <= in_ready_d;
      out_valid  <= out_valid_d;
      out_last   <= out_last_d;
      frame_done <= frame_done_d;
      overflow   <= overflow_d;
      if (rd_en) begin
        out_data <= rd_q_c;
      end
    end
  end

  // Column write into the feature-map buffer
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int unsigned r = 0; r < OUT_SIZE; r++) begin
        mem[CNT_W'(r)][col_cnt] <= in_data[CNT_W'(r)];
      end
    end
  end

  col_requant u_requant (
    .x   (mem[row_cnt][drain_col]),
    .y_c (rd_q_c)
  );

endmodule

// File: tb/tb_conv_col_collector.sv
// Directed bench for conv_col_collector: ramp, saturation, backpressure,
// gapped input, overflow and reset-abort scenarios.
module tb_conv_col_collector;

  localparam int N = 24;
  localparam int TOTAL = N * N;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               in_valid = 1'b0;
  logic signed [31:0] in_data [N];
  logic               in_ready;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic signed [15:0] out_data;
  logic               out_last;
  logic               frame_done;
  logic               overflow;

  int          checks = 0;
  int          failures = 0;
  logic [15:0] got [TOTAL];
  int          n_got, last_at, stall_err;
  bit          fd_ok, drain_to;
  int          bad_k;
  logic [15:0] bad_got, bad_exp;

  conv_col_collector dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .frame_done (frame_done),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Input pattern: mode 0 = ramp, mode 1 = saturation mix
  function automatic logic [31:0] pat(input int mode, input int r, input int c);
    int k;
    k = r * N + c;
    if (mode == 0) return 32'(k) << 8;
    case (k % 4)
      0:       return 32'h7FFF_FFFF;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FF00;
      default: return 32'(k) << 8;
    endcase
  endfunction

  function automatic logic [15:0] exp_val(input int mode, input int k);
    if (mode == 0) return 16'(k);
    case (k % 4)
      0: return 16'h7FFF;
`ifdef CONV_COLL_RELU_EN
      1: return 16'h0000;
      2: return 16'h0000;
`else
      1: return 16'h8000;
      2: return 16'hFFFF;
`endif
      default: return 16'(k);
    endcase
  endfunction

  // Number of collected words that differ from the mode's expected frame
  function automatic int frame_errs(input int mode);
    int e;
    e = 0;
    for (int k = 0; k < TOTAL; k++) begin
      if (got[k] !== exp_val(mode, k)) begin
        if (e == 0) begin
          bad_k = k; bad_got = got[k]; bad_exp = exp_val(mode, k);
        end
        e++;
      end
    end
    return e;
  endfunction

  task automatic send_frame(input int mode, input int gap, input int ncols);
    int w;
    for (int c = 0; c < ncols; c++) begin
      w = 0;
      while (in_ready !== 1'b1) begin
        @(posedge clk); #1;
        w++;
        if (w > 100) begin
          failures++;
          $display("FAIL in_ready_wait col=%0d in_ready=%b required=1", c, in_ready);
          return;
        end
      end
      for (int r = 0; r < N; r++) in_data[r] = pat(mode, r, c);
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (gap) begin
        @(posedge clk); #1;
      end
    end
  endtask

  // Collect drained words with pct% ready; stops on frame_done, stop_at or timeout
  task automatic drain(input int pct, input int stop_at);
    int          cyc;
    bit          stalled, await_fd, rdy;
    logic [15:0] held_d;
    logic        held_l;
    n_got = 0; last_at = -1; fd_ok = 0; stall_err = 0; drain_to = 0;
    cyc = 0; stalled = 0; await_fd = 0; held_d = '0; held_l = 1'b0;
    while (1) begin
      if (await_fd) begin
        fd_ok = (frame_done === 1'b1) && (out_valid === 1'b0);
        break;
      end
      if (n_got >= stop_at) break;
      if (cyc >= 20000) begin
        drain_to = 1;
        break;
      end
      if (stalled && (out_valid !== 1'b1 || out_data !== held_d || out_last !== held_l))
        stall_err++;
      rdy = ($urandom_range(99) < pct);
      out_ready = rdy;
      stalled = 0;
      if (out_valid === 1'b1) begin
        if (rdy) begin
          if (n_got < TOTAL) got[n_got] = out_data;
          if (out_last === 1'b1) begin
            last_at = n_got;
            await_fd = 1;
          end
          n_got++;
        end else begin
          stalled = 1; held_d = out_data; held_l = out_last;
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    for (int r = 0; r < N; r++) in_data[r] = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b required=0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b required=0", out_valid); end
    checks++; if (out_data !== 16'h0) begin failures++; $display("FAIL reset_out_data got=%h required=0000", out_data); end
    checks++; if (out_last !== 1'b0 || frame_done !== 1'b0 || overflow !== 1'b0) begin
      failures++; $display("FAIL reset_flags got=%b%b%b required=000", out_last, frame_done, overflow);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL idle_in_ready got=%b required=1", in_ready); end
  endtask

  task automatic test_ramp();
    send_frame(0, 0, N);
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL ramp_drain_in_ready got=%b required=0", in_ready); end
    drain(100, TOTAL);
    checks++; if (drain_to !== 1'b0 || n_got !== TOTAL) begin failures++; $display("FAIL ramp_count got=%0d required=%0d timeout=%b", n_got, TOTAL, drain_to); end
    checks++; if (frame_errs(0) !== 0) begin failures++; $display("FAIL ramp_data k=%0d got=%h required=%h", bad_k, bad_got, bad_exp); end
    checks++; if (last_at !== TOTAL - 1) begin failures++; $display("FAIL ramp_last got=%0d required=%0d", last_at, TOTAL - 1); end
    checks++; if (fd_ok !== 1'b1) begin failures++; $display("FAIL ramp_frame_done got=%b required=1", fd_ok); end
    @(posedge clk); #1;
    checks++; if (frame_done !== 1'b0 || in_ready !== 1'b1) begin
      failures++; $display("FAIL ramp_post got fd=%b in_ready=%b required fd=0 in_ready=1", frame_done, in_ready);
    end
  endtask

  task automatic test_saturation();
    send_frame(1, 0, N);
    drain(100, TOTAL);
    checks++; if (n_got !== TOTAL) begin failures++; $display("FAIL sat_count got=%0d required=%0d", n_got, TOTAL); end
    checks++; if (got[0] !== 16'h7FFF) begin failures++; $display("FAIL sat_max got=%h required=7fff", got[0]); end
`ifdef CONV_COLL_RELU_EN
    checks++; if (got[1] !== 16'h0000) begin failures++; $display("FAIL sat_min_relu got=%h required=0000", got[1]); end
    checks++; if (got[2] !== 16'h0000) begin failures++; $display("FAIL sat_neg1_relu got=%h required=0000", got[2]); end
`else
    checks++; if (got[1] !== 16'h8000) begin failures++; $display("FAIL sat_min got=%h required=8000", got[1]); end
    checks++; if (got[2] !== 16'hFFFF) begin failures++; $display("FAIL sat_neg1 got=%h required=ffff", got[2]); end
`endif
    checks++; if (frame_errs(1) !== 0) begin failures++; $display("FAIL sat_data k=%0d got=%h required=%h", bad_k, bad_got, bad_exp); end
  endtask

  task automatic test_backpressure();
    send_frame(0, 0, N);
    drain(30, TOTAL);
    checks++; if (drain_to !== 1'b0 || n_got !== TOTAL) begin failures++; $display("FAIL bp_count got=%0d required=%0d timeout=%b", n_got, TOTAL, drain_to); end
    checks++; if (stall_err !== 0) begin failures++; $display("FAIL bp_stable got=%0d required=0", stall_err); end
    checks++; if (frame_errs(0) !== 0) begin failures++; $display("FAIL bp_data k=%0d got=%h required=%h", bad_k, bad_got, bad_exp); end
    checks++; if (last_at !== TOTAL - 1 || fd_ok !== 1'b1) begin failures++; $display("FAIL bp_last got=%0d fd=%b required=%0d fd=1", last_at, fd_ok, TOTAL - 1); end
  endtask

  task automatic test_gapped();
    send_frame(0, 2, N);
    drain(100, TOTAL);
    checks++; if (n_got !== TOTAL) begin failures++; $display("FAIL gap_count got=%0d required=%0d", n_got, TOTAL); end
    checks++; if (frame_errs(0) !== 0) begin failures++; $display("FAIL gap_data k=%0d got=%h required=%h", bad_k, bad_got, bad_exp); end
  endtask

  task automatic test_overflow();
    send_frame(0, 0, N);
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_pre got=%b required=0", overflow); end
    for (int r = 0; r < N; r++) in_data[r] = 32'h1234_5600;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_set got=%b required=1", overflow); end
    drain(100, TOTAL);
    checks++; if (frame_errs(0) !== 0 || n_got !== TOTAL) begin failures++; $display("FAIL ovf_data k=%0d got=%h required=%h n=%0d", bad_k, bad_got, bad_exp, n_got); end
    send_frame(0, 0, N);
    drain(100, TOTAL);
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%b required=1", overflow); end
    rst = 1'b1; #1;
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_clear got=%b required=0", overflow); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    send_frame(0, 0, 10);
    rst = 1'b1; #1;
    checks++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin failures++; $display("FAIL rst_cap got in_ready=%b out_valid=%b required 0 0", in_ready, out_valid); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    send_frame(0, 0, N);
    drain(100, 100);
    checks++; if (out_valid !== 1'b1 || got[99] !== 16'd99) begin failures++; $display("FAIL rst_pre_drain got valid=%b w99=%h required valid=1 w99=0063", out_valid, got[99]); end
    rst = 1'b1; #1;
    checks++; if (out_valid !== 1'b0 || out_last !== 1'b0 || frame_done !== 1'b0) begin
      failures++; $display("FAIL rst_drain got %b%b%b required 000", out_valid, out_last, frame_done);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0 || frame_done !== 1'b0 || in_ready !== 1'b1) begin
      failures++; $display("FAIL rst_idle got valid=%b fd=%b in_ready=%b required 0 0 1", out_valid, frame_done, in_ready);
    end
    send_frame(0, 0, N);
    drain(100, TOTAL);
    checks++; if (frame_errs(0) !== 0 || n_got !== TOTAL || fd_ok !== 1'b1) begin
      failures++; $display("FAIL rst_recover k=%0d got=%h required=%h n=%0d fd=%b", bad_k, bad_got, bad_exp, n_got, fd_ok);
    end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_saturation();
    test_backpressure();
    test_gapped();
    test_overflow();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
